// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO: binary/gray
// write pointer, two-flop read-pointer synchronizer, registered full flag.
module fifo_wptr_full #(
    parameter int p_addr_width = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_val,
    output logic                    enq_rdy,
    output logic                    wen,
    output logic [p_addr_width-1:0] waddr,
    output logic [p_addr_width:0]   wptr_gray,
    input  logic [p_addr_width:0]   rptr_gray_in,
    output logic                    full,
    output logic [p_addr_width:0]   count
);

    localparam int PW = p_addr_width + 1;
    typedef logic [PW-1:0] ptr_t;

    // Full when the write pointer is exactly one lap ahead: in gray code that
    // means the top two bits differ from the read pointer and the rest match.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (p_addr_width - 1);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        logic acc;
        acc = 1'b0;
        for (int i = PW - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    ptr_t wbin;
    ptr_t wbin_next;
    ptr_t wgray_next;
    ptr_t s1;
    ptr_t rptr_sync;
    ptr_t rbin_sync;

    assign enq_rdy    = ~full;
    assign wen        = enq_val & enq_rdy;
    assign waddr      = wbin[p_addr_width-1:0];
    assign wbin_next  = wbin + ptr_t'(wen);
    assign wgray_next = bin2gray(wbin_next);
    assign rbin_sync  = gray2bin(rptr_sync);
    assign count      = wbin - rbin_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            wbin      <= '0;
            wptr_gray <= '0;
            s1        <= '0;
            rptr_sync <= '0;
            full      <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            // rptr_gray_in is asynchronous; only rptr_sync is ever consumed.
            s1        <= rptr_gray_in;
            rptr_sync <= s1;
            full      <= (wgray_next == (rptr_sync ^ FULL_MASK));
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed and randomized bench for fifo_wptr_full (depth 4), checked against
// an occupancy-based reference model with a two-sample read-pointer delay.
module tb_fifo_wptr_full;

    localparam int A = 2;
    localparam int D = 1 << A;
    localparam int M = 2 * D;

    logic         clk = 1'b0;
    logic         reset;
    logic         enq_val;
    logic         enq_rdy;
    logic         wen;
    logic [A-1:0] waddr;
    logic [A:0]   wptr_gray;
    logic [A:0]   rptr_gray_in;
    logic         full;
    logic [A:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: write count, full flag, and the read-pointer samples
    // taken at the last two edges (oldest first).
    int wb;
    bit full_m;
    int rq[$];
    int prev_g;
    int rb_in;

    fifo_wptr_full #(.p_addr_width(A)) dut (
        .clk          (clk),
        .reset        (reset),
        .enq_val      (enq_val),
        .enq_rdy      (enq_rdy),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .rptr_gray_in (rptr_gray_in),
        .full         (full),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) % M;
    endfunction

    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
        return b % M;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int occ_expected();
        return (wb - g2b(rq[0]) + M) % M;
    endfunction

    task automatic step(input logic rst, input logic en, input int rp);
        int wenm;
        int wbn;
        int rbo;
        reset        = rst;
        enq_val      = en;
        rptr_gray_in = rp[A:0];
        #1;
        if (!rst) begin
            chk("wen", wen, (en && !full_m) ? 1 : 0);
            chk("enq_rdy_pre", enq_rdy, full_m ? 0 : 1);
        end
        @(posedge clk);
        if (rst) begin
            wb     = 0;
            full_m = 0;
            rq     = '{0, 0};
        end else begin
            wenm   = (en && !full_m) ? 1 : 0;
            wbn    = (wb + wenm) % M;
            rbo    = g2b(rq[0]);
            full_m = (((wbn - rbo + M) % M) == D);
            wb     = wbn;
            void'(rq.pop_front());
            rq.push_back(rp);
        end
        #1;
        chk("wptr_gray", wptr_gray, b2g(wb));
        chk("full", full, full_m);
        chk("enq_rdy", enq_rdy, full_m ? 0 : 1);
        chk("waddr", waddr, wb % D);
        chk("count", count, occ_expected());
        if (!rst) chk("gray_step", ($countones(prev_g[A:0] ^ wptr_gray) <= 1) ? 1 : 0, 1);
        prev_g = int'(wptr_gray);
    endtask

    initial begin
        int gseq[4];
        int avail;
        logic en_r;
        gseq = '{1, 3, 2, 6};
        wb = 0; full_m = 0; rq = '{0, 0}; prev_g = 0; rb_in = 0;
        reset = 1'b1; enq_val = 1'b0; rptr_gray_in = '0;

        // Reset state
        step(1, 0, 0);
        step(1, 0, 0);
        chk("rst_wptr", wptr_gray, 0);
        chk("rst_full", full, 0);
        chk("rst_rdy", enq_rdy, 1);
        chk("rst_count", count, 0);

        // Fill to full with the read pointer parked at zero
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            chk("fill_gray", wptr_gray, gseq[i]);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_rdy", enq_rdy, 0);

        // Pushes while full are dropped
        step(0, 1, 0);
        step(0, 1, 0);
        chk("hold_gray", wptr_gray, 6);
        chk("hold_waddr", waddr, 0);
        #1;
        chk("hold_wen", wen, 0);

        // One read: full clears on the third edge after the change
        step(0, 0, 1);
        chk("rd_full_e1", full, 1);
        step(0, 0, 1);
        chk("rd_full_e2", full, 1);
        step(0, 0, 1);
        chk("rd_full_e3", full, 0);
        chk("rd_count", count, 3);
        step(0, 1, 1);
        chk("refill_gray", wptr_gray, 7);
        chk("refill_full", full, 1);

        // Reset while full with a push pending
        step(1, 1, 1);
        chk("midrst_gray", wptr_gray, 0);
        chk("midrst_full", full, 0);
        chk("midrst_count", count, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // Wrap: reader keeps up so the FIFO never fills
        for (int i = 0; i < 8; i++) begin
            step(0, 1, b2g(wb));
            if (i == 6) begin
                chk("wrap_gray7", wptr_gray, 4);
                chk("wrap_waddr7", waddr, 3);
            end
        end
        chk("wrap_gray0", wptr_gray, 0);
        chk("wrap_waddr0", waddr, 0);
        chk("wrap_nofull", full, 0);

        // Randomized traffic with a legal, lagging read pointer
        step(1, 0, 0);
        rb_in = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rb_in = 0;
                step(1, 1'($urandom_range(0, 1)), 0);
            end else begin
                avail = (wb - rb_in + M) % M;
                if ($urandom_range(0, 2) == 0)
                    rb_in = (rb_in + $urandom_range(0, avail)) % M;
                en_r = ($urandom_range(0, 3) != 0);
                step(0, en_r, b2g(rb_in));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
